axi4_burst_master: RTL and testbench
====================================

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 ACLK  input  1  single clock; all logic is rising-edge.
REQ-004 ARESETn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write/cmd_addr/cmd_len/cmd_size  in  1/ADDR_WIDTH/8/3  direction (1=write), base byte address, beats-1, log2 bytes per beat.
REQ-007 wr_valid/wr_ready/wr_data  in/out/in  1/1/DATA_WIDTH  write-payload stream.
REQ-008 rd_valid/rd_ready/rd_data/rd_last/rd_resp  out/in/out/out/out  1/1/DATA_WIDTH/1/2  read-payload stream.
REQ-009 done/done_resp  out  1/2  one-cycle completion pulse and final response.
REQ-010 AWADDR/AWLEN/AWSIZE/AWVALID out, AWREADY in  ADDR_WIDTH/8/3/1/1  write-address channel.
REQ-011 WDATA/WLAST/WVALID out, WREADY in  DATA_WIDTH/1/1/1  write-data channel.
REQ-012 BRESP/BVALID in, BREADY out  2/1/1  write-response channel.
REQ-013 ARADDR/ARLEN/ARSIZE/ARVALID out, ARREADY in  ADDR_WIDTH/8/3/1/1  read-address channel.
REQ-014 RDATA/RRESP/RLAST/RVALID in, RREADY out  DATA_WIDTH/2/1/1/1  read-data channel.

Function
REQ-015 FSM states IDLE, AW, W, B, AR, R, DONE; exactly one transaction in flight at a time.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, capture all cmd fields, load beat counter = cmd_len+1 (9 bits), go to AW (write) or AR (read).
REQ-017 AW: AWVALID=1 with captured fields, held stable until AWREADY; on handshake go to W.
REQ-018 W: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data (combinational pass-through, zero added latency); each WVALID&&WREADY decrements the counter.
REQ-019 WLAST=1 exactly when counter==1; after last-beat handshake go to B.
REQ-020 B: BREADY=1; on BVALID capture BRESP, go to DONE.
REQ-021 AR: ARVALID=1 held stable until ARREADY; on handshake go to R.
REQ-022 R: rd_valid=RVALID, RREADY=rd_ready, rd_data/rd_resp/rd_last=RDATA/RRESP/RLAST pass-through; counter decrements per handshake.
REQ-023 Read response accumulates as worst of all beats (SLVERR=2'b10 sticky over OKAY).
REQ-024 R exits to DONE on the handshake where counter==1, independent of RLAST; RLAST on any earlier beat is ignored.
REQ-025 DONE: done=1 for exactly one cycle with done_resp; next state IDLE; cmd_ready=0 in every state except IDLE.
REQ-026 Beat counter never underflows; cmd_len=255 yields 256 beats.
REQ-027 AWSIZE/ARSIZE pass cmd_size unchanged; no address increment logic in this block.

Reset
REQ-028 On ARESETn low: state IDLE, all VALID/READY outputs 0, AW*/AR*/WDATA/rd_data 0, done=0, done_resp=2'b00, counter 0.
REQ-029 Reset mid-burst abandons the transaction immediately; no done pulse is issued for it.

Configuration
REQ-030 Macro AXI4_BURST_MASTER_4K_CHECK_EN: when defined, a command whose (addr&12'hFFF)+((len+1)<<size)-1 > 12'hFFF skips all bus channels and goes IDLE->DONE with done_resp=2'b10; the write variant consumes and discards len+1 wr_data beats first (wr_ready=1).
REQ-031 Without the macro, every command is issued on the bus unchanged.

Structure
REQ-032 Shared package axi4_pkg holds resp codes (OKAY=2'b00, SLVERR=2'b10), FSM state enum, and 4KB boundary constant 12'hFFF.
REQ-033 Single module; no sub-module.

Verification
REQ-034 Write addr=0x0010, len=3, size=2, slave accepts immediately -> AW once, 4 W beats, WLAST on 4th only, done_resp=00.
REQ-035 Read addr=0x0040, len=0 -> single R beat, rd_last=1, done pulse 1 cycle after handshake.
REQ-036 Slave holds AWREADY low 5 cycles -> AWVALID/AWADDR stable throughout, no W beat issued early.
REQ-037 Read len=3, RRESP=10 on beat 2 only -> done_resp=10.
REQ-038 Macro defined, write addr=0x0FF0, len=7, size=2 -> no AWVALID, 8 wr beats drained, done_resp=10; macro undefined -> AW issued.
REQ-039 ARESETn asserted during W beat 2 of 4 -> all outputs zero same cycle, IDLE after release, no done pulse.

Source files
------------

// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared definitions for the AXI4 burst master:
//   - AXI response codes used by the response accumulator
//   - burst master FSM state encoding
//   - 4KB page offset mask and the page-crossing helper that the optional
//     page check uses (macro AXI4_BURST_MASTER_4K_CHECK_EN in the top file)
// -----------------------------------------------------------------------------
package axi4_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [11:0] BOUNDARY_4K = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  // Worst-of two responses. Encodings grow in severity, so the numerically
  // larger code wins; SLVERR therefore sticks once seen.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  // True when a burst starting at page offset `offset` with (len+1) beats of
  // 2**size bytes runs past the end of its 4KB page. 20 bits covers the
  // largest span (256 beats x 128 bytes) plus the offset without overflow.
  function automatic logic crosses_4k(input logic [11:0] offset,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
    logic [19:0] span;
    logic [19:0] last_byte;
    span      = ({12'd0, len} + 20'd1) << size;
    last_byte = {8'd0, offset} + span - 20'd1;
    return last_byte > {8'd0, BOUNDARY_4K};
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_master
// Single-outstanding AXI4 burst master. A command (direction, base address,
// beats-1, log2 beat size) is accepted in IDLE and run as one AXI burst; the
// write payload and read payload are streamed straight through to/from the
// W and R channels with no buffering. A one-cycle done pulse reports the
// final response (BRESP for writes, worst RRESP for reads).
//
// Ports
//   ACLK, ARESETn                  clock, async active-low reset
//   cmd_valid/ready, cmd_write,    command handshake and fields
//   cmd_addr, cmd_len, cmd_size
//   wr_valid/ready, wr_data        write-payload stream (into the block)
//   rd_valid/ready, rd_data,       read-payload stream (out of the block)
//   rd_last, rd_resp
//   done, done_resp                completion pulse and final response
//   AW*, W*, B*, AR*, R*           AXI4 master channels
//
// Build option
//   AXI4_BURST_MASTER_4K_CHECK_EN  when defined, bursts that cross a 4KB page
//                                  are refused without touching the bus: a
//                                  write drains its payload, then both
//                                  directions finish with SLVERR.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a command
// ST_AW   | write address presented, waiting for AWREADY
// ST_W    | write beats streaming (or payload being discarded)
// ST_B    | waiting for the write response
// ST_AR   | read address presented, waiting for ARREADY
// ST_R    | read beats streaming
// ST_DONE | one-cycle completion pulse
// -----------------------------------------------------------------------------
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,

  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,

  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            rd_resp,

  output logic                  done,
  output logic [1:0]            done_resp,

  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,

  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,

  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,

  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,

  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  state_t                  state_q, state_d;
  logic [8:0]              cnt_q, cnt_d;     // beats remaining, 1..256
  logic [1:0]              resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic                    active_q;         // holds cmd_ready low until out of reset
  logic                    drop_q;           // current write payload is being discarded
  logic                    cmd_hs;
  logic                    w_hs;
  logic                    r_hs;

`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
  logic                    drop_d;
`endif

  // ---------------------------------------------------------------------------
  // Channel outputs: all derived from the registered state so that they drop
  // to zero the instant reset is applied.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = active_q && (state_q == ST_IDLE);

    AWVALID   = (state_q == ST_AW);
    AWADDR    = addr_q;
    AWLEN     = len_q;
    AWSIZE    = size_q;

    ARVALID   = (state_q == ST_AR);
    ARADDR    = addr_q;
    ARLEN     = len_q;
    ARSIZE    = size_q;

    WVALID    = 1'b0;
    WDATA     = '0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    if (state_q == ST_W) begin
      if (drop_q) begin
        wr_ready = 1'b1;
      end else begin
        WVALID   = wr_valid;
        WDATA    = wr_data;
        WLAST    = (cnt_q == 9'd1);
        wr_ready = WREADY;
      end
    end

    BREADY    = (state_q == ST_B);

    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_resp   = RESP_OKAY;
    rd_last   = 1'b0;
    if (state_q == ST_R) begin
      RREADY   = rd_ready;
      rd_valid = RVALID;
      rd_data  = RDATA;
      rd_resp  = RRESP;
      rd_last  = RLAST;
    end

    done      = (state_q == ST_DONE);
    done_resp = resp_q;
  end

  assign cmd_hs = cmd_valid && cmd_ready;
  assign w_hs   = (state_q == ST_W) && wr_valid && wr_ready;
  assign r_hs   = (state_q == ST_R) && RVALID && rd_ready;

  // ---------------------------------------------------------------------------
  // Next state. The beat counter, not RLAST, ends a read burst.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
    drop_d  = drop_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          cnt_d   = {1'b0, cmd_len} + 9'd1;
          resp_d  = RESP_OKAY;
          state_d = cmd_write ? ST_AW : ST_AR;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
          drop_d  = 1'b0;
          if (crosses_4k(cmd_addr[11:0], cmd_len, cmd_size)) begin
            resp_d = RESP_SLVERR;
            if (cmd_write) begin
              drop_d  = 1'b1;
              state_d = ST_W;
            end else begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end
          end
`endif
        end
      end

      ST_AW: begin
        if (AWREADY) state_d = ST_W;
      end

      ST_W: begin
        if (w_hs) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = drop_q ? ST_DONE : ST_B;
        end
      end

      ST_B: begin
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = ST_DONE;
        end
      end

      ST_AR: begin
        if (ARREADY) state_d = ST_R;
      end

      ST_R: begin
        if (r_hs) begin
          cnt_d  = cnt_q - 9'd1;
          resp_d = worst_resp(resp_q, RRESP);
          if (cnt_q == 9'd1) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      resp_q   <= RESP_OKAY;
      active_q <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      active_q <= 1'b1;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        size_q <= cmd_size;
      end
    end
  end

`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) drop_q <= 1'b0;
    else          drop_q <= drop_d;
  end
`else
  assign drop_q = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          done;
  logic [1:0]    done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic          WLAST, WVALID, WREADY;
  logic [1:0]    BRESP, RRESP;
  logic          BVALID, BREADY, RLAST, RVALID, RREADY;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_resp(rd_resp),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration
  int         aw_delay    = 0;
  logic [1:0] bresp_cfg   = 2'b00;
  int         r_bad_idx   = -1;
  int         r_early_idx = -1;

  // scoreboard queues: {addr,len,size}, {last,data}, {resp,last,data}, resp
  logic [26:0] aw_q[$];
  logic [26:0] ar_q[$];
  logic [32:0] w_q[$];
  logic [34:0] rd_q[$];
  logic [1:0]  done_q[$];

  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_word(input logic [15:0] base, input int idx);
    return {16'hA000, base} + 32'(idx);
  endfunction

  // ---------------------------------------------------------------------------
  // Slave model: samples handshakes at negedge, updates its drives just after
  // the following rising edge.
  // ---------------------------------------------------------------------------
  initial begin
    logic aw_hs, ar_hs, b_hs, r_hs;
    logic [15:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [15:0] r_base;
    int aw_wait, r_idx, r_total;
    AWREADY = 0; WREADY = 1; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 32'hDEAD_BEEF; RRESP = 0; RLAST = 0;
    aw_wait = 0; r_idx = 0; r_total = 0; r_base = 0;
    forever begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      ar_hs = ARVALID && ARREADY;
      b_hs  = BVALID && BREADY;
      r_hs  = RVALID && RREADY;
      ar_addr_s = ARADDR;
      ar_len_s  = ARLEN;
      @(posedge ACLK);
      #1;
      if (!ARESETn) begin
        AWREADY = 0; aw_wait = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
      end else begin
        if (aw_hs) begin
          AWREADY = 0; aw_wait = 0;
        end else if (AWVALID && !AWREADY) begin
          if (aw_wait >= aw_delay) AWREADY = 1;
          else aw_wait++;
        end
        if (ar_hs) ARREADY = 0;
        else if (ARVALID && !ARREADY) ARREADY = 1;
        if (b_hs) BVALID = 0;
        else if (BREADY && !BVALID) begin
          BVALID = 1; BRESP = bresp_cfg;
        end
        if (ar_hs) begin
          r_total = int'(ar_len_s) + 1; r_base = ar_addr_s; r_idx = 0;
        end else if (r_hs) begin
          r_idx++;
        end
        if ((ar_hs || r_hs) && r_idx < r_total) begin
          RVALID = 1;
          RDATA  = r_word(r_base, r_idx);
          RRESP  = (r_idx == r_bad_idx) ? 2'b10 : 2'b00;
          RLAST  = (r_idx == r_total - 1) || (r_idx == r_early_idx);
        end else if (r_hs) begin
          RVALID = 0; RLAST = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations as the DUT produces channel traffic.
  // ---------------------------------------------------------------------------
  initial begin
    logic [26:0] ea;
    logic [32:0] ew;
    logic [34:0] er;
    logic        done_prev;
    done_prev = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (AWVALID && AWREADY) begin
        check("aw_expected", 64'(aw_q.size() != 0), 64'd1);
        if (aw_q.size() != 0) begin
          ea = aw_q.pop_front();
          check("awaddr", 64'(AWADDR), 64'(ea[26:11]));
          check("awlen",  64'(AWLEN),  64'(ea[10:3]));
          check("awsize", 64'(AWSIZE), 64'(ea[2:0]));
        end
      end
      if (ARVALID && ARREADY) begin
        check("ar_expected", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) begin
          ea = ar_q.pop_front();
          check("araddr", 64'(ARADDR), 64'(ea[26:11]));
          check("arlen",  64'(ARLEN),  64'(ea[10:3]));
          check("arsize", 64'(ARSIZE), 64'(ea[2:0]));
        end
      end
      if (WVALID && WREADY) begin
        check("w_expected", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) begin
          ew = w_q.pop_front();
          check("wdata", 64'(WDATA), 64'(ew[31:0]));
          check("wlast", 64'(WLAST), 64'(ew[32]));
        end
      end
      if (rd_valid && rd_ready) begin
        rd_cyc = cyc;
        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          er = rd_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(er[31:0]));
          check("rd_last", 64'(rd_last), 64'(er[32]));
          check("rd_resp", 64'(rd_resp), 64'(er[34:33]));
        end
      end
      if (done) begin
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) check("done_resp", 64'(done_resp), 64'(done_q.pop_front()));
        check("done_single_cycle", 64'(done_prev), 64'd0);
        check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
        done_cyc = cyc;
        done_cnt++;
      end
      if (AWVALID || ARVALID || BREADY) check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      done_prev = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic exp_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [31:0] base);
    aw_q.push_back({a, l, s});
    for (int i = 0; i <= int'(l); i++) w_q.push_back({(i == int'(l)), base + 32'(i)});
  endtask

  task automatic exp_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                          input int bad, input int early);
    ar_q.push_back({a, l, s});
    for (int i = 0; i <= int'(l); i++)
      rd_q.push_back({((i == bad) ? 2'b10 : 2'b00), (i == int'(l)) || (i == early), r_word(a, i)});
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1; break; end
    end
    check("cmd_accepted", 64'(ok), 64'd1);
    @(posedge ACLK);
    #1;
    cmd_valid = 0;
  endtask

  task automatic send_wr(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bit ok;
      ok = 0;
      wr_valid = 1;
      wr_data  = base + 32'(i);
      for (int k = 0; k < 50; k++) begin
        @(negedge ACLK);
        if (wr_ready) begin ok = 1; break; end
      end
      check("wr_accepted", 64'(ok), 64'd1);
      @(posedge ACLK);
      #1;
    end
    wr_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      #2;
      if (done_cnt > start) begin ok = 1; break; end
    end
    check("done_seen", 64'(ok), 64'd1);
    @(posedge ACLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  stall;
    bit  seen_hs;
    ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    wr_valid = 1; wr_data = 32'hCAFE_F00D; rd_ready = 1;

    // reset state (payload inputs deliberately non-zero)
    repeat (3) @(negedge ACLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_awvalid",   64'(AWVALID),   64'd0);
    check("rst_arvalid",   64'(ARVALID),   64'd0);
    check("rst_wvalid",    64'(WVALID),    64'd0);
    check("rst_wdata",     64'(WDATA),     64'd0);
    check("rst_wr_ready",  64'(wr_ready),  64'd0);
    check("rst_bready",    64'(BREADY),    64'd0);
    check("rst_rready",    64'(RREADY),    64'd0);
    check("rst_rd_data",   64'(rd_data),   64'd0);
    check("rst_awaddr",    64'(AWADDR),    64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_done_resp", 64'(done_resp), 64'd0);
    @(posedge ACLK);
    #1;
    wr_valid = 0; ARESETn = 1;
    repeat (2) @(negedge ACLK);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge ACLK);
    #1;

    // write 0x0010, 4 beats, slave ready at once
    exp_write(16'h0010, 8'd3, 3'd2, 32'h1111_0000);
    done_q.push_back(2'b00);
    send_cmd(1, 16'h0010, 8'd3, 3'd2);
    send_wr(4, 32'h1111_0000);
    wait_done(50);

    // single-beat read, done one cycle after the R handshake
    exp_read(16'h0040, 8'd0, 3'd2, -1, -1);
    done_q.push_back(2'b00);
    send_cmd(0, 16'h0040, 8'd0, 3'd2);
    wait_done(50);
    check("done_after_rd_hs", 64'(done_cyc - rd_cyc), 64'd1);

    // AWREADY held off 5 cycles; address stable, no early W; BRESP captured
    aw_delay = 5; bresp_cfg = 2'b10;
    exp_write(16'h0120, 8'd1, 3'd2, 32'h3300_0000);
    done_q.push_back(2'b10);
    send_cmd(1, 16'h0120, 8'd1, 3'd2);
    wr_valid = 1; wr_data = 32'h3300_0000;
    stall = 0; seen_hs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ACLK);
      if (AWVALID && AWREADY) begin seen_hs = 1; break; end
      if (AWVALID) begin
        stall++;
        check("aw_stall_addr", 64'(AWADDR), 64'h0120);
        check("aw_stall_len",  64'(AWLEN),  64'd1);
        check("w_not_early",   64'(WVALID), 64'd0);
        check("wr_ready_not_early", 64'(wr_ready), 64'd0);
      end
    end
    check("aw_handshake_seen", 64'(seen_hs), 64'd1);
    check("aw_stall_cycles", 64'(stall), 64'd5);
    @(posedge ACLK);
    #1;
    aw_delay = 0;
    send_wr(2, 32'h3300_0000);
    wait_done(50);
    bresp_cfg = 2'b00;

    // 4-beat read, SLVERR on beat 2, stray RLAST on beat 2 must not end it
    r_bad_idx = 1; r_early_idx = 1;
    exp_read(16'h0080, 8'd3, 3'd2, 1, 1);
    done_q.push_back(2'b10);
    send_cmd(0, 16'h0080, 8'd3, 3'd2);
    wait_done(50);
    r_bad_idx = -1; r_early_idx = -1;

    // read ending exactly on the last byte of the page is never refused
    exp_read(16'h0FF0, 8'd3, 3'd2, -1, -1);
    done_q.push_back(2'b00);
    send_cmd(0, 16'h0FF0, 8'd3, 3'd2);
    wait_done(50);

    // page-crossing write and read
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
    done_q.push_back(2'b10);
    send_cmd(1, 16'h0FF0, 8'd7, 3'd2);
    send_wr(8, 32'h5500_0000);
    wait_done(50);
    done_q.push_back(2'b10);
    send_cmd(0, 16'h0FFC, 8'd1, 3'd2);
    wait_done(50);
`else
    exp_write(16'h0FF0, 8'd7, 3'd2, 32'h5500_0000);
    done_q.push_back(2'b00);
    send_cmd(1, 16'h0FF0, 8'd7, 3'd2);
    send_wr(8, 32'h5500_0000);
    wait_done(50);
    exp_read(16'h0FFC, 8'd1, 3'd2, -1, -1);
    done_q.push_back(2'b00);
    send_cmd(0, 16'h0FFC, 8'd1, 3'd2);
    wait_done(50);
`endif

    // reset while beat 2 of 4 is being offered
    exp_write(16'h0200, 8'd3, 3'd2, 32'h6600_0000);
    void'(w_q.pop_back()); void'(w_q.pop_back()); void'(w_q.pop_back());
    send_cmd(1, 16'h0200, 8'd3, 3'd2);
    send_wr(1, 32'h6600_0000);
    wr_valid = 1; wr_data = 32'h6600_0001;
    ARESETn = 0;
    #1;
    check("mid_rst_wvalid",   64'(WVALID),    64'd0);
    check("mid_rst_wdata",    64'(WDATA),     64'd0);
    check("mid_rst_wr_ready", 64'(wr_ready),  64'd0);
    check("mid_rst_awaddr",   64'(AWADDR),    64'd0);
    check("mid_rst_bready",   64'(BREADY),    64'd0);
    check("mid_rst_cmd_rdy",  64'(cmd_ready), 64'd0);
    check("mid_rst_done",     64'(done),      64'd0);
    wr_valid = 0;
    repeat (2) @(negedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETn = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      check("no_done_after_rst", 64'(done), 64'd0);
    end
    check("idle_after_rst", 64'(cmd_ready), 64'd1);

    check("aw_q_empty",   64'(aw_q.size()),   64'd0);
    check("ar_q_empty",   64'(ar_q.size()),   64'd0);
    check("w_q_empty",    64'(w_q.size()),    64'd0);
    check("rd_q_empty",   64'(rd_q.size()),   64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
